module_task_regpipe: RTL and testbench
======================================

// Module: module_task_regpipe
// PURPOSE
//  Parametrised successor of the single 4-bit task-driven register: a DEPTH-stage elastic
//  register pipeline, WIDTH bits wide, with valid/ready flow control and a per-beat opcode.
//  Each accepted beat is transformed once at stage 0 by a next-value task. The beat then
//  shifts to the output with bubble collapsing. Sits between task-style producers and consumers.
// PARAMETERS
//  WIDTH  4  data width in bits (>=1)
//  DEPTH  2  number of register stages (>=1); also the minimum latency in cycles
//  CNT_W  8  width of the accepted-beat counter (only with MODULE_TASK_CNT_EN)
// PORTS
//  in_task_clk    in   1        clock, rising edge
//  in_task_rst    in   1        asynchronous reset, active-low
//  in_task_valid  in   1        input beat valid
//  out_task_ready out  1        pipeline can accept a beat this cycle
//  in_task_data   in   WIDTH    input data
//  in_task_op     in   2        op_e: 0 PASS, 1 CLEAR, 2 INVERT, 3 INCR
//  in_task_flush  in   1        synchronous flush of all stages
//  out_task_valid out  1        output beat valid (= last stage valid)
//  in_task_ready  in   1        downstream accepts output beat
//  out_task_reg   out  WIDTH    output data (= last stage data)
//  out_task_count out  CNT_W    accepted-beat count (only with MODULE_TASK_CNT_EN)
// BEHAVIOUR
//  - Reset (in_task_rst=0, async): all stage valid=0, all data=0, out_task_reg=0, count=0.
//  - Input transfer: in_task_valid && out_task_ready. Output transfer: out_task_valid && in_task_ready.
//  - Stage k advances when stage k+1 is empty or advancing. The last stage advances on output transfer.
//  - out_task_ready = !v[0] || stage 0 advances. This is combinational from in_task_ready through the chain.
//  - Full throughput: one beat per cycle when in_task_ready is held 1. Latency is DEPTH cycles, input to out_task_valid.
//  - Stage 0 load uses task compute_next_reg_value(data, op) -> next:
//    PASS=data; CLEAR=0; INVERT=~data; INCR=data+1, modulo 2^WIDTH (all-ones wraps to 0).
//  - Stalled stages hold data and valid unchanged. A stall never drops or duplicates beats.
//  - Empty stages hold their stale data. Only the valid bit is cleared.
//  - in_task_flush=1: next edge clears all valid bits. Same-cycle input is not accepted, even if ready.
//    Same-cycle output transfer still counts downstream. Data registers are not cleared.
//  - Reset asserted mid-stream: all in-flight beats are lost immediately. After release the pipeline is empty.
//  - out_task_valid never deasserts without an output transfer or a flush. out_task_reg stays stable while stalled.
// CONFIGURATION
//  - MODULE_TASK_CNT_EN defined: adds out_task_count, which increments on each input transfer.
//    The counter saturates at all-ones. Flush does not clear it; only reset clears it.
//  - MODULE_TASK_CNT_EN undefined: no out_task_count port, no counter logic.
//    All other behaviour is identical.
// STRUCTURE
//  - Package module_task_pkg holds:
//    typedef enum logic [1:0] op_e {OP_PASS, OP_CLEAR, OP_INVERT, OP_INCR};
//    the automatic task compute_next_reg_value, parametrised via a WIDTH argument or a localparam
//  - Sub-module module_task_stage: one valid+data register with load/hold/flush.
//    It is instantiated DEPTH times in a generate loop.
//  - Top level holds the advance chain, the stage-0 transform and the optional counter.
// TESTING
//  - Reset: WIDTH=4, DEPTH=2, hold rst low mid-stream.
//    Expect out_task_valid=0, out_task_reg=0 asynchronously and out_task_ready=1 after release.
//  - Ops: send 4'h5 with PASS, CLEAR, INVERT, then 4'hF with INCR, in_task_ready=1.
//    Expect outputs 5, 0, A, 0 in order, each 2 cycles after its input.
//  - Backpressure: fill with 1,2,3 while in_task_ready=0.
//    Expect out_task_ready=0 after 2 beats and out_task_reg held at 1.
//    After release, expect outputs 1,2,3 with no loss or duplication.
//  - Bubble collapse: DEPTH=3, one beat, then in_task_ready=0 for 5 cycles, then 2 more beats.
//    Expect all three stages valid and out_task_ready=0.
//  - Flush with in_task_valid=1 on a full pipe: next cycle all valid=0.
//    The flushed-cycle input must not appear at the output.
//  - With MODULE_TASK_CNT_EN and CNT_W=2: send 5 beats. Expect count to saturate at 3 and stay at 3 after a flush.

Source files
------------

// File: rtl/module_task_regpipe_pkg.sv
// Shared opcode type and stage-0 next-value task for the task-driven register pipeline.
// The task works on a MAX_W-bit container and masks the result to the caller's width.
package module_task_pkg;

  typedef enum logic [1:0] {OP_PASS, OP_CLEAR, OP_INVERT, OP_INCR} op_e;

  localparam int unsigned MAX_W = 64;

  task automatic compute_next_reg_value(
    input  logic [MAX_W-1:0] data,
    input  op_e              op,
    input  int unsigned      width,
    output logic [MAX_W-1:0] next
  );
    logic [MAX_W-1:0] mask;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    case (op)
      OP_PASS:   next = data;
      OP_CLEAR:  next = '0;
      OP_INVERT: next = ~data;
      default:   next = data + MAX_W'(1);
    endcase
    // masking gives INVERT its width and makes INCR wrap modulo 2^width
    next = next & mask;
  endtask

endpackage

// File: rtl/module_task_regpipe_stage.sv
// One elastic pipeline stage: valid+data register, 1-cycle latency; holds when load is low.
// Flush clears only the valid bit; a bubble load clears valid and keeps the stale data.
module module_task_stage #(
  parameter int WIDTH = 4
) (
  input  logic             in_task_clk,
  input  logic             in_task_rst,
  input  logic             load,
  input  logic             flush,
  input  logic             src_vld,
  input  logic [WIDTH-1:0] src_dat,
  output logic             stg_vld,
  output logic [WIDTH-1:0] stg_dat
);

  always_ff @(posedge in_task_clk or negedge in_task_rst) begin
    if (!in_task_rst) begin
      stg_vld <= 1'b0;
      stg_dat <= '0;
    end else if (flush) begin
      stg_vld <= 1'b0;
    end else if (load) begin
      stg_vld <= src_vld;
      if (src_vld) stg_dat <= src_dat;
    end
  end

endmodule

// File: rtl/module_task_regpipe.sv
// DEPTH-stage valid/ready register pipeline with a stage-0 opcode transform; latency DEPTH cycles.
// Ready is combinational from in_task_ready, so empty stages collapse; MODULE_TASK_CNT_EN adds a saturating beat counter.
module module_task_regpipe
  import module_task_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
`ifdef MODULE_TASK_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             in_task_clk,
  input  logic             in_task_rst,
  input  logic             in_task_valid,
  output logic             out_task_ready,
  input  logic [WIDTH-1:0] in_task_data,
  input  logic [1:0]       in_task_op,
  input  logic             in_task_flush,
  output logic             out_task_valid,
  input  logic             in_task_ready,
  output logic [WIDTH-1:0] out_task_reg
`ifdef MODULE_TASK_CNT_EN
  ,
  output logic [CNT_W-1:0] out_task_count
`endif
);

  logic [DEPTH-1:0] stg_vld;
  logic [WIDTH-1:0] stg_dat [DEPTH];
  logic [DEPTH-1:0] load;
  logic [MAX_W-1:0] nxt_ext;
  logic             nxt_unused;

  // A stage may load when downstream accepts or any stage at or after it is empty.
  genvar k;
  for (k = 0; k < DEPTH; k++) begin : g_load
    assign load[k] = in_task_ready | ~(&stg_vld[DEPTH-1:k]);
  end

  assign out_task_ready = load[0];
  assign out_task_valid = stg_vld[DEPTH-1];
  assign out_task_reg   = stg_dat[DEPTH-1];

  always_comb begin
    nxt_ext = '0;
    compute_next_reg_value(MAX_W'(in_task_data), op_e'(in_task_op), WIDTH, nxt_ext);
  end

  assign nxt_unused = ^nxt_ext;

  for (k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      module_task_stage #(.WIDTH(WIDTH)) u_stage (
        .in_task_clk (in_task_clk),
        .in_task_rst (in_task_rst),
        .load        (load[0]),
        .flush       (in_task_flush),
        .src_vld     (in_task_valid),
        .src_dat     (nxt_ext[WIDTH-1:0]),
        .stg_vld     (stg_vld[0]),
        .stg_dat     (stg_dat[0])
      );
    end else begin : g_body
      module_task_stage #(.WIDTH(WIDTH)) u_stage (
        .in_task_clk (in_task_clk),
        .in_task_rst (in_task_rst),
        .load        (load[k]),
        .flush       (in_task_flush),
        .src_vld     (stg_vld[k-1]),
        .src_dat     (stg_dat[k-1]),
        .stg_vld     (stg_vld[k]),
        .stg_dat     (stg_dat[k])
      );
    end
  end

`ifdef MODULE_TASK_CNT_EN
  logic in_xfer;
  assign in_xfer = in_task_valid & load[0] & ~in_task_flush;

  always_ff @(posedge in_task_clk or negedge in_task_rst) begin
    if (!in_task_rst) begin
      out_task_count <= '0;
    end else if (in_xfer && (out_task_count != '1)) begin
      out_task_count <= out_task_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_module_task_regpipe.sv
// Bench for module_task_regpipe: table-driven op vectors, corner sequences and a randomized scoreboard run.
module tb_module_task_regpipe;
  import module_task_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_vld = 1'b0, a_rdy, a_flush = 1'b0, a_ovld, a_ordy = 1'b1;
  logic [3:0] a_dat = '0, a_oreg;
  logic [1:0] a_op = '0;
  logic       b_vld = 1'b0, b_rdy, b_flush = 1'b0, b_ovld, b_ordy = 1'b1;
  logic [3:0] b_dat = '0, b_oreg;
  logic [1:0] b_op = '0;
`ifdef MODULE_TASK_CNT_EN
  logic [1:0] a_cnt;
  logic [1:0] b_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  module_task_regpipe #(
    .WIDTH(4), .DEPTH(2)
`ifdef MODULE_TASK_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .in_task_clk(clk), .in_task_rst(rst_n), .in_task_valid(a_vld), .out_task_ready(a_rdy),
    .in_task_data(a_dat), .in_task_op(a_op), .in_task_flush(a_flush), .out_task_valid(a_ovld),
    .in_task_ready(a_ordy), .out_task_reg(a_oreg)
`ifdef MODULE_TASK_CNT_EN
    , .out_task_count(a_cnt)
`endif
  );

  module_task_regpipe #(
    .WIDTH(4), .DEPTH(3)
`ifdef MODULE_TASK_CNT_EN
    , .CNT_W(2)
`endif
  ) dut3 (
    .in_task_clk(clk), .in_task_rst(rst_n), .in_task_valid(b_vld), .out_task_ready(b_rdy),
    .in_task_data(b_dat), .in_task_op(b_op), .in_task_flush(b_flush), .out_task_valid(b_ovld),
    .in_task_ready(b_ordy), .out_task_reg(b_oreg)
`ifdef MODULE_TASK_CNT_EN
    , .out_task_count(b_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference transform from the opcode definitions, in plain integer arithmetic.
  function automatic logic [3:0] ref_next(input logic [3:0] d, input logic [1:0] op);
    int v;
    case (op)
      2'd0:    v = int'(d);
      2'd1:    v = 0;
      2'd2:    v = 15 - int'(d);
      default: v = (int'(d) + 1) % 16;
    endcase
    return v[3:0];
  endfunction

  // Called at a negedge with downstream ready and no input; pops exp_q on each output transfer.
  task automatic drain(input bit sel, input string nm);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      #1;
      if (sel ? b_ovld : a_ovld) chk(nm, sel ? b_oreg : a_oreg, exp_q.pop_front());
      guard++;
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      chk({nm, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    #1;
    chk({nm, "_empty"}, sel ? b_ovld : a_ovld, 0);
  endtask

  typedef struct {
    logic [3:0] data;
    logic [1:0] op;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic       pv, pxfer, pfl;
    logic [3:0] preg;

    tbl[0] = '{4'h5, 2'd0, 4'h5};
    tbl[1] = '{4'h5, 2'd1, 4'h0};
    tbl[2] = '{4'h5, 2'd2, 4'hA};
    tbl[3] = '{4'hF, 2'd3, 4'h0};
    tbl[4] = '{4'h0, 2'd3, 4'h1};
    tbl[5] = '{4'hA, 2'd2, 4'h5};
    tbl[6] = '{4'h7, 2'd0, 4'h7};
    tbl[7] = '{4'h9, 2'd1, 4'h0};
    tbl[8] = '{4'hE, 2'd3, 4'hF};

    #1;
    chk("rst_vld", a_ovld, 0);
    chk("rst_reg", a_oreg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", a_rdy, 1);

    // Ops table, back to back, each result DEPTH cycles after its input.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i < 9) begin
        a_vld = 1'b1; a_dat = tbl[i].data; a_op = tbl[i].op;
      end else begin
        a_vld = 1'b0;
      end
      #1;
      chk("ops_rdy", a_rdy, 1);
      if (i >= 2) begin
        chk("ops_vld", a_ovld, 1);
        chk($sformatf("ops_reg%0d", i - 2), a_oreg, tbl[i-2].exp);
      end
    end
    @(negedge clk);
    #1;
    chk("ops_idle", a_ovld, 0);

    // Backpressure: two beats fill DEPTH=2, third waits.
    @(negedge clk);
    a_ordy = 1'b0; a_vld = 1'b1; a_dat = 4'h1; a_op = OP_PASS;
    #1; chk("bp_rdy0", a_rdy, 1);
    @(negedge clk);
    a_dat = 4'h2;
    #1; chk("bp_rdy1", a_rdy, 1);
    @(negedge clk);
    a_dat = 4'h3;
    #1; chk("bp_full", a_rdy, 0); chk("bp_vld", a_ovld, 1); chk("bp_reg", a_oreg, 1);
    repeat (3) begin
      @(negedge clk);
      #1; chk("bp_hold_reg", a_oreg, 1); chk("bp_hold_rdy", a_rdy, 0);
    end
    @(negedge clk);
    a_ordy = 1'b1;
    #1; chk("bp_comb_rdy", a_rdy, 1); chk("bp_out1", a_oreg, 1);
    @(negedge clk);
    a_vld = 1'b0;
    exp_q = '{4'h2, 4'h3};
    drain(1'b0, "bp_out");

    // Flush a full pipe while input is offered and an output transfer happens.
    @(negedge clk);
    a_ordy = 1'b0; a_vld = 1'b1; a_dat = 4'h4; a_op = OP_PASS;
    @(negedge clk);
    a_dat = 4'h6;
    @(negedge clk);
    #1; chk("fl_full", a_rdy, 0);
    a_flush = 1'b1; a_dat = 4'hC; a_ordy = 1'b1;
    #1; chk("fl_rdy", a_rdy, 1); chk("fl_out", a_oreg, 4);
    @(negedge clk);
    a_flush = 1'b0; a_vld = 1'b0;
    #1; chk("fl_vld", a_ovld, 0); chk("fl_rdy_after", a_rdy, 1);
    repeat (4) begin
      @(negedge clk);
      #1; chk("fl_no_beat", a_ovld, 0);
    end

    // Bubble collapse on DEPTH=3.
    @(negedge clk);
    b_ordy = 1'b0; b_vld = 1'b1; b_dat = 4'h3; b_op = OP_INVERT;
    @(negedge clk);
    b_vld = 1'b0;
    repeat (4) @(negedge clk);
    #1; chk("bub_vld", b_ovld, 1); chk("bub_reg", b_oreg, 4'hC); chk("bub_rdy", b_rdy, 1);
    @(negedge clk);
    b_vld = 1'b1; b_dat = 4'h7; b_op = OP_PASS;
    #1; chk("bub_rdy1", b_rdy, 1);
    @(negedge clk);
    b_dat = 4'h0; b_op = OP_INCR;
    #1; chk("bub_rdy2", b_rdy, 1);
    @(negedge clk);
    b_vld = 1'b0;
    #1; chk("bub_full", b_rdy, 0); chk("bub_last", b_oreg, 4'hC);
    b_ordy = 1'b1;
    exp_q = '{4'hC, 4'h7, 4'h1};
    drain(1'b1, "bub_out");

    // Randomized run against a queue scoreboard.
    exp_q.delete();
    pv = 1'b0; pxfer = 1'b0; pfl = 1'b0; preg = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      a_vld   = ($urandom_range(0, 3) != 0);
      a_dat   = 4'($urandom);
      a_op    = 2'($urandom);
      a_ordy  = ($urandom_range(0, 2) != 0);
      a_flush = ($urandom_range(0, 15) == 0);
      #1;
      chk("rnd_rdy", a_rdy, ((exp_q.size() < 2) || a_ordy) ? 1 : 0);
      if (pv && !pxfer && !pfl) begin
        chk("rnd_hold_vld", a_ovld, 1);
        chk("rnd_hold_reg", a_oreg, preg);
      end
      if (a_ovld) chk("rnd_nonempty", (exp_q.size() != 0) ? 1 : 0, 1);
      if (a_ovld && a_ordy && exp_q.size() > 0) chk("rnd_data", a_oreg, exp_q.pop_front());
      if (a_flush) exp_q.delete();
      else if (a_vld && a_rdy) exp_q.push_back(ref_next(a_dat, a_op));
      pv = a_ovld; pxfer = a_ovld & a_ordy; pfl = a_flush; preg = a_oreg;
    end
    @(negedge clk);
    a_vld = 1'b0; a_flush = 1'b0; a_ordy = 1'b1;
    drain(1'b0, "rnd_drain");

    // Reset asserted mid-stream drops in-flight beats asynchronously.
    @(negedge clk);
    a_vld = 1'b1; a_dat = 4'h9; a_op = OP_PASS;
    @(negedge clk);
    a_dat = 4'h8;
    @(negedge clk);
    #1; chk("mrst_pre", a_ovld, 1);
    #2 rst_n = 1'b0;
    #1; chk("mrst_vld", a_ovld, 0); chk("mrst_reg", a_oreg, 0);
    a_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1; chk("mrst_rdy", a_rdy, 1);
    repeat (3) begin
      @(negedge clk);
      #1; chk("mrst_empty", a_ovld, 0);
    end

`ifdef MODULE_TASK_CNT_EN
    chk("cnt_rst", a_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_vld = 1'b1; a_dat = 4'(i); a_op = OP_PASS;
      if (i == 2) begin
        #1; chk("cnt_two", a_cnt, 2);
      end
    end
    @(negedge clk);
    a_vld = 1'b0;
    #1; chk("cnt_sat", a_cnt, 3);
    @(negedge clk);
    a_flush = 1'b1;
    @(negedge clk);
    a_flush = 1'b0;
    #1; chk("cnt_flush", a_cnt, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
